mdio_master: RTL and testbench



---
 rtl/mdio_master.sv | 136 +++++++++++++
 tb/tb_mdio_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// Clause-22 MDIO station manager: serialises one read/write command into a
// preamble + 32-bit frame on MDC/MDIO and returns read data with a TA error flag.
module mdio_master #(
  parameter int CLK_DIV = 5,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [5:0] LAST_BIT = 6'(PRE_LEN + 31);
  localparam logic [5:0] PRE_L = 6'(PRE_LEN);

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;
  state_t state, state_nxt;

  logic [DW-1:0] cnt;
  logic          ph;
  logic [5:0]    bit_cnt, nb, k_cur, k_nb;
  logic [31:0]   fr;
  logic          wr, ta_bad, ta_nxt, o_nxt, oe_nxt;
  logic [15:0]   rd_sh, sh_nxt;
  logic          accept, bit_end, sample;

  assign cmd_ready = (state == IDLE) || (state == DONE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state == DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign bit_end   = busy && ph && (cnt == DIV_LAST);
  // rising MDC edge: first high-phase cycle
  assign sample    = busy && ph && (cnt == '0);
  assign nb        = bit_cnt + 6'd1;
  assign k_cur     = bit_cnt - PRE_L;
  assign k_nb      = nb - PRE_L;

  function automatic state_t seg(input logic [5:0] n);
    logic [5:0] k;
    k = n - PRE_L;
    if (int'(n) < PRE_LEN) return PRE;
    else if (k < 6'd14)    return HDR;
    else if (k < 6'd16)    return TA;
    else                   return DATA;
  endfunction

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? ((PRE_LEN > 0) ? PRE : HDR) : IDLE;
      default:    if (bit_end) state_nxt = (bit_cnt == LAST_BIT) ? DONE : seg(nb);
    endcase
  end

  // Drive values for the next bit; a read releases the bus from TA onwards.
  always_comb begin
    o_nxt  = 1'b1;
    oe_nxt = 1'b1;
    if (int'(nb) >= PRE_LEN) begin
      if (!wr && int'(k_nb) >= 14) oe_nxt = 1'b0;
      else                         o_nxt  = fr[~k_nb[4:0]];
    end
  end

  assign sh_nxt = (sample && state == DATA) ? {rd_sh[14:0], mdio_i} : rd_sh;
  assign ta_nxt = (sample && state == TA && k_cur == 6'd15) ? mdio_i : ta_bad;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt       <= '0;
      ph        <= 1'b0;
      bit_cnt   <= '0;
      fr        <= '0;
      wr        <= 1'b0;
      ta_bad    <= 1'b0;
      rd_sh     <= '0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      fr      <= {2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy_addr, cmd_reg_addr, 2'b10, cmd_wdata};
      wr      <= cmd_write;
      cnt     <= '0;
      ph      <= 1'b0;
      bit_cnt <= '0;
      ta_bad  <= 1'b0;
      rd_sh   <= '0;
      mdc     <= 1'b0;
      mdio_o  <= (PRE_LEN > 0) ? 1'b1 : 1'b0;
      mdio_oe <= 1'b1;
    end else if (busy) begin
      rd_sh  <= sh_nxt;
      ta_bad <= ta_nxt;
      if (cnt == DIV_LAST) begin
        cnt <= '0;
        if (!ph) begin
          ph  <= 1'b1;
          mdc <= 1'b1;
        end else if (bit_cnt == LAST_BIT) begin
          ph      <= 1'b0;
          mdc     <= 1'b0;
          mdio_o  <= 1'b1;
          mdio_oe <= 1'b0;
          if (!wr) rsp_rdata <= sh_nxt;
          rsp_err <= !wr && ta_nxt;
        end else begin
          ph      <= 1'b0;
          mdc     <= 1'b0;
          bit_cnt <= nb;
          mdio_o  <= o_nxt;
          mdio_oe <= oe_nxt;
        end
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: two instances (default and PRE_LEN=0/CLK_DIV=1), a
// cycle-level waveform model with a PHY responder, directed and random frames.
module tb_mdio_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        cmd_valid [2], cmd_ready [2], cmd_write [2];
  logic [4:0]  cmd_phy_addr [2], cmd_reg_addr [2];
  logic [15:0] cmd_wdata [2], rsp_rdata [2];
  logic        rsp_valid [2], rsp_err [2], busy [2];
  logic        mdc [2], mdio_o [2], mdio_oe [2], bus [2];
  logic        phy_en [2], phy_val [2];

  assign bus[0] = mdio_oe[0] ? mdio_o[0] : (phy_en[0] ? phy_val[0] : 1'b1);
  assign bus[1] = mdio_oe[1] ? mdio_o[1] : (phy_en[1] ? phy_val[1] : 1'b1);

  mdio_master #(.CLK_DIV(5), .PRE_LEN(32)) dut0 (
    .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_write(cmd_write[0]), .cmd_phy_addr(cmd_phy_addr[0]), .cmd_reg_addr(cmd_reg_addr[0]),
    .cmd_wdata(cmd_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0]), .mdc(mdc[0]), .mdio_o(mdio_o[0]),
    .mdio_oe(mdio_oe[0]), .mdio_i(bus[0]));

  mdio_master #(.CLK_DIV(1), .PRE_LEN(0)) dut1 (
    .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_write(cmd_write[1]), .cmd_phy_addr(cmd_phy_addr[1]), .cmd_reg_addr(cmd_reg_addr[1]),
    .cmd_wdata(cmd_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1]), .mdc(mdc[1]), .mdio_o(mdio_o[1]),
    .mdio_oe(mdio_oe[1]), .mdio_i(bus[1]));

  int checks = 0, errors = 0;
  int DV [2], PV [2];

  // model state per instance
  bit          active [2], fwr [2];
  int          t [2], fmode [2], resp_mode [2];
  logic [63:0] fb [2], stream [2], last_stream [2];
  logic [15:0] frd [2], resp_data [2], hold_rd [2];
  logic        hold_err [2], prev_mdc [2];
  int          done_cnt [2], acc_cnt [2], acc_t [2];
  int          edges [2], first_off [2], valid_t [2], pulses [2];
  int          last_edges [2], last_off [2], last_valid_t [2], last_pulses [2];

  task automatic chk(input int i, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got %0h, want %0h @%0t", i, name, act, exp, $time);
    end
  endtask

  // One call per falling clk edge: t counts cycles since acceptance (cycle 0).
  task automatic model_step(input int i);
    int d, p, lastt, n;
    logic hi, eoe, eo, obs;
    logic [31:0] word;
    d = DV[i]; p = PV[i]; lastt = 2 * (p + 32) * d + 1;
    phy_en[i] = 1'b0; phy_val[i] = 1'b1;
    if (rst[i]) begin
      active[i] = 1'b0; hold_rd[i] = '0; hold_err[i] = 1'b0; prev_mdc[i] = 1'b0;
      chk(i, "rst_ready", cmd_ready[i], 1); chk(i, "rst_busy", busy[i], 0);
      chk(i, "rst_mdc", mdc[i], 0); chk(i, "rst_oe", mdio_oe[i], 0);
      chk(i, "rst_o", mdio_o[i], 1); chk(i, "rst_valid", rsp_valid[i], 0);
      chk(i, "rst_rdata", rsp_rdata[i], 0); chk(i, "rst_err", rsp_err[i], 0);
      return;
    end
    if (active[i]) begin
      t[i]++;
      if (t[i] > lastt) active[i] = 1'b0;
    end
    if (active[i] && t[i] < lastt) begin
      n   = (t[i] - 1) / (2 * d);
      hi  = ((t[i] - 1) % (2 * d)) >= d;
      eoe = fwr[i] || (n < p + 14);
      eo  = eoe ? fb[i][n] : 1'b1;
      if (!fwr[i] && fmode[i] != 0 && n >= p + 15) begin
        phy_en[i] = 1'b1;
        if (n == p + 15) phy_val[i] = (fmode[i] == 2);
        else             phy_val[i] = frd[i][31 - (n - p)];
      end
      chk(i, "mdc", mdc[i], hi); chk(i, "mdio_oe", mdio_oe[i], eoe);
      chk(i, "mdio_o", mdio_o[i], eo); chk(i, "ready_busy", {cmd_ready[i], busy[i]}, 2'b01);
      chk(i, "valid", rsp_valid[i], 0);
      chk(i, "rdata_hold", rsp_rdata[i], hold_rd[i]); chk(i, "err_hold", rsp_err[i], hold_err[i]);
      if (rsp_valid[i]) begin pulses[i]++; valid_t[i] = t[i]; end
      obs = mdio_oe[i] ? mdio_o[i] : (phy_en[i] ? phy_val[i] : 1'b1);
      if (mdc[i] && !prev_mdc[i]) begin edges[i]++; stream[i] = {stream[i][62:0], obs}; end
      if (!mdio_oe[i] && first_off[i] < 0) first_off[i] = n;
    end else if (active[i]) begin
      if (!fwr[i]) begin
        hold_rd[i]  = (fmode[i] == 0) ? 16'hFFFF : frd[i];
        hold_err[i] = (fmode[i] != 1);
      end else hold_err[i] = 1'b0;
      chk(i, "done_valid", rsp_valid[i], 1); chk(i, "done_ready_busy", {cmd_ready[i], busy[i]}, 2'b10);
      chk(i, "done_mdc", mdc[i], 0); chk(i, "done_oe", mdio_oe[i], 0);
      chk(i, "done_rdata", rsp_rdata[i], hold_rd[i]); chk(i, "done_err", rsp_err[i], hold_err[i]);
      if (rsp_valid[i]) begin pulses[i]++; valid_t[i] = t[i]; end
      done_cnt[i]++;
      last_edges[i] = edges[i]; last_stream[i] = stream[i]; last_off[i] = first_off[i];
      last_valid_t[i] = valid_t[i]; last_pulses[i] = pulses[i];
    end else begin
      chk(i, "idle_mdc", mdc[i], 0); chk(i, "idle_oe", mdio_oe[i], 0);
      chk(i, "idle_ready_busy", {cmd_ready[i], busy[i]}, 2'b10); chk(i, "idle_valid", rsp_valid[i], 0);
      chk(i, "idle_rdata", rsp_rdata[i], hold_rd[i]); chk(i, "idle_err", rsp_err[i], hold_err[i]);
    end
    prev_mdc[i] = mdc[i];
    if (cmd_valid[i] && (!active[i] || t[i] == lastt)) begin
      acc_t[i] = active[i] ? t[i] : -1;
      acc_cnt[i]++;
      active[i] = 1'b1; t[i] = 0; fwr[i] = cmd_write[i];
      fmode[i] = resp_mode[i]; frd[i] = resp_data[i];
      word = {2'b01, cmd_write[i] ? 2'b01 : 2'b10, cmd_phy_addr[i], cmd_reg_addr[i], 2'b10, cmd_wdata[i]};
      for (int b = 0; b < 64; b++) begin
        if (b < p)           fb[i][b] = 1'b1;
        else if (b < p + 32) fb[i][b] = word[31 - (b - p)];
        else                 fb[i][b] = 1'b0;
      end
      edges[i] = 0; stream[i] = '0; first_off[i] = -1; valid_t[i] = -1; pulses[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic send(input int i, input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                      input logic [15:0] wd, input int mode, input logic [15:0] rd, input bit keep);
    int a0, c;
    @(posedge clk); #1;
    cmd_write[i] = wr; cmd_phy_addr[i] = pa; cmd_reg_addr[i] = ra; cmd_wdata[i] = wd;
    resp_mode[i] = mode; resp_data[i] = rd; cmd_valid[i] = 1'b1;
    a0 = acc_cnt[i]; c = 0;
    while (acc_cnt[i] == a0 && c < 2000) begin @(posedge clk); #1; c++; end
    chk(i, "accept_seen", acc_cnt[i] != a0, 1);
    if (!keep) begin
      cmd_valid[i] = 1'b0;
      cmd_write[i] = 1'($urandom); cmd_phy_addr[i] = 5'($urandom);
      cmd_reg_addr[i] = 5'($urandom); cmd_wdata[i] = 16'($urandom);
    end
  endtask

  task automatic wait_done(input int i, input int target);
    int c;
    c = 0;
    while (done_cnt[i] < target && c < 3000) begin @(posedge clk); #1; c++; end
    chk(i, "done_seen", done_cnt[i] >= target, 1);
  endtask

  initial begin
    int d0, d1, c, m;
    DV[0] = 5; PV[0] = 32; DV[1] = 1; PV[1] = 0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; cmd_valid[i] = 1'b0; cmd_write[i] = 1'b0;
      cmd_phy_addr[i] = '0; cmd_reg_addr[i] = '0; cmd_wdata[i] = '0;
      phy_en[i] = 1'b0; phy_val[i] = 1'b1; active[i] = 1'b0; t[i] = 0;
      resp_mode[i] = 0; resp_data[i] = '0; hold_rd[i] = '0; hold_err[i] = 1'b0;
      prev_mdc[i] = 1'b0; done_cnt[i] = 0; acc_cnt[i] = 0; acc_t[i] = -1;
      fwr[i] = 1'b0; fmode[i] = 0; frd[i] = '0; fb[i] = '0; stream[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1; rst[0] = 1'b0; rst[1] = 1'b0;

    // Directed write with default parameters
    d0 = done_cnt[0];
    send(0, 1'b1, 5'h01, 5'h1A, 16'hA5C3, 0, 16'h0, 1'b0);
    wait_done(0, d0 + 1);
    chk(0, "t1_edges", last_edges[0], 64);
    chk(0, "t1_stream", last_stream[0], {32'hFFFF_FFFF, 32'h50EA_A5C3});
    chk(0, "t1_valid_cycle", last_valid_t[0], 641);
    chk(0, "t1_err", rsp_err[0], 0);

    // Read answered by the PHY model
    send(0, 1'b0, 5'h01, 5'h02, 16'h0, 1, 16'h1234, 1'b0);
    wait_done(0, d0 + 2);
    chk(0, "t2_oe_drop_bit", last_off[0], 46);
    chk(0, "t2_rdata", rsp_rdata[0], 16'h1234);
    chk(0, "t2_err", rsp_err[0], 0);

    // Read with nobody answering
    send(0, 1'b0, 5'h1F, 5'h00, 16'h0, 0, 16'h5555, 1'b0);
    wait_done(0, d0 + 3);
    chk(0, "t3_rdata", rsp_rdata[0], 16'hFFFF);
    chk(0, "t3_err", rsp_err[0], 1);
    chk(0, "t3_pulses", last_pulses[0], 1);

    // Back-to-back: valid held high, second accepted in DONE
    send(0, 1'b1, 5'h0A, 5'h15, 16'h3C3C, 0, 16'h0, 1'b1);
    send(0, 1'b0, 5'h0B, 5'h16, 16'h0, 1, 16'hCAFE, 1'b0);
    chk(0, "t4_accept_cycle", acc_t[0], 641);
    wait_done(0, d0 + 5);
    chk(0, "t4_rdata", rsp_rdata[0], 16'hCAFE);
    chk(0, "t4_edges", last_edges[0], 64);

    // Reset at bit 20 of a read
    d0 = done_cnt[0];
    send(0, 1'b0, 5'h03, 5'h04, 16'h0, 1, 16'hBEEF, 1'b0);
    c = 0;
    while (t[0] < 201 && c < 1000) begin @(posedge clk); #1; c++; end
    chk(0, "t5_reached_bit20", t[0] >= 201, 1);
    #1 rst[0] = 1'b1;
    #1;
    chk(0, "t5_mdc", mdc[0], 0); chk(0, "t5_oe", mdio_oe[0], 0);
    chk(0, "t5_ready", cmd_ready[0], 1); chk(0, "t5_valid", rsp_valid[0], 0);
    @(posedge clk); #1; rst[0] = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    chk(0, "t5_no_rsp", done_cnt[0], d0);
    send(0, 1'b1, 5'h07, 5'h08, 16'h0F0F, 0, 16'h0, 1'b0);
    wait_done(0, d0 + 1);
    chk(0, "t5_next_edges", last_edges[0], 64);
    chk(0, "t5_next_rdata", rsp_rdata[0], 16'h0);

    // Random frames with a stray mid-frame request
    for (int k = 0; k < 5; k++) begin
      d0 = done_cnt[0];
      m = $urandom_range(0, 2);
      send(0, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), m, 16'($urandom), 1'b0);
      repeat ($urandom_range(10, 400)) @(posedge clk);
      #1; cmd_valid[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1; cmd_valid[0] = 1'b0;
      wait_done(0, d0 + 1);
      chk(0, "rnd_pulses", last_pulses[0], 1);
    end

    // Preamble suppression, CLK_DIV=1
    d1 = done_cnt[1];
    send(1, 1'b1, 5'h00, 5'h00, 16'h0001, 0, 16'h0, 1'b0);
    wait_done(1, d1 + 1);
    chk(1, "t6_edges", last_edges[1], 32);
    chk(1, "t6_stream", last_stream[1][31:0], 32'h5002_0001);
    chk(1, "t6_first_bit", last_stream[1][31], 0);
    chk(1, "t6_valid_cycle", last_valid_t[1], 65);

    for (int k = 0; k < 30; k++) begin
      d1 = done_cnt[1];
      m = $urandom_range(0, 2);
      send(1, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), m, 16'($urandom), 1'b0);
      wait_done(1, d1 + 1);
      chk(1, "rnd_edges", last_edges[1], 32);
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
